// File: rtl/mult8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier driving an external 8-bit adder.
// Optional MULT8_ZERO_SKIP_EN: zero operands complete in one cycle without iterating.
module mult8_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic [7:0]  add_a,
   output logic [7:0]  add_b,
   output logic        add_cin,
   input  logic [7:0]  add_sum,
   input  logic        add_cout
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state_r, state_s;
   logic [7:0]  m_r, m_s;
   logic [7:0]  q_r, q_s;
   logic [7:0]  acc_r, acc_s;
   logic [3:0]  cnt_r, cnt_s;
   logic [15:0] product_r, product_s;
   logic [8:0]  partial_s;
   logic        zero_op_s;

   // Zero-operand shortcut detection
   always_comb begin
`ifdef MULT8_ZERO_SKIP_EN
      zero_op_s = (a == 8'h00) || (b == 8'h00);
`else
      zero_op_s = 1'b0;
`endif
   end

   // Partial sum {C,S}: adder result when the multiplier LSB is set, else ACC unchanged
   always_comb begin
      if (q_r[0]) begin
         partial_s = {add_cout, add_sum};
      end else begin
         partial_s = {1'b0, acc_r};
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_s   = state_r;
      m_s       = m_r;
      q_s       = q_r;
      acc_s     = acc_r;
      cnt_s     = cnt_r;
      product_s = product_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               m_s   = a;
               q_s   = b;
               acc_s = 8'h00;
               cnt_s = 4'd0;
               if (zero_op_s) begin
                  state_s   = DONE;
                  product_s = 16'h0000;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            // {ACC,Q} <= {C, S, Q[7:1]}
            acc_s = partial_s[8:1];
            q_s   = {partial_s[0], q_r[7:1]};
            cnt_s = cnt_r + 4'd1;
            if (cnt_r == 4'd7) begin
               state_s   = DONE;
               product_s = {partial_s, q_r[7:1]};
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         m_r       <= 8'h00;
         q_r       <= 8'h00;
         acc_r     <= 8'h00;
         cnt_r     <= 4'd0;
         product_r <= 16'h0000;
      end else begin
         state_r   <= state_s;
         m_r       <= m_s;
         q_r       <= q_s;
         acc_r     <= acc_s;
         cnt_r     <= cnt_s;
         product_r <= product_s;
      end
   end

   assign busy    = (state_r == RUN);
   assign done    = (state_r == DONE);
   assign product = product_r;
   assign add_a   = acc_r;
   assign add_b   = m_r;
   assign add_cin = 1'b0;

endmodule

// File: tb/tb_mult8_seq.sv
// Randomized self-checking bench for mult8_seq; the adder is modelled behaviourally
// and every result is compared against plain a*b with edge-count timing expectations.
module tb_mult8_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic        add_cin;
   logic [7:0]  add_sum;
   logic        add_cout;

   int total = 0;
   int bad = 0;
   logic [15:0] prev_prod;
   logic        cout_seen;

   mult8_seq dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_latency(input logic [7:0] x, input logic [7:0] y);
`ifdef MULT8_ZERO_SKIP_EN
      if (x == 8'h00 || y == 8'h00) return 0;
`endif
      return 8;
   endfunction

   // One complete operation: accept, track busy/done timing, compare the product
   task automatic mult_op(input logic [7:0] x, input logic [7:0] y, input string tag);
      int cyc;
      int busy_cnt;
      logic stable;
      a = x;
      b = y;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cyc = 0;
      busy_cnt = 0;
      stable = 1'b1;
      cout_seen = 1'b0;
      while (!done && cyc < 30) begin
         if (busy) busy_cnt++;
         if (busy && add_cout) cout_seen = 1'b1;
         if (product !== prev_prod) stable = 1'b0;
         tick();
         cyc++;
      end
      check_value({tag, "_lat"}, 32'(cyc), 32'(exp_latency(x, y)));
      check_value({tag, "_busy"}, 32'(busy_cnt), 32'(exp_latency(x, y)));
      check_value({tag, "_hold"}, {31'd0, stable}, 32'd1);
      check_value({tag, "_prod"}, {16'd0, product}, {16'd0, 16'(x) * 16'(y)});
      prev_prod = 16'(x) * 16'(y);
      tick();
      check_value({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int dones;
      int times[$];
      rst = 1'b1;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      prev_prod = 16'h0000;
      cout_seen = 1'b0;
      #2;
      check_value("rst_busy", {31'd0, busy}, 32'd0);
      check_value("rst_done", {31'd0, done}, 32'd0);
      check_value("rst_prod", {16'd0, product}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      mult_op(8'h0D, 8'h0B, "d_by_b");
      mult_op(8'hFF, 8'hFF, "ff_by_ff");
      check_value("ff_cout_seen", {31'd0, cout_seen}, 32'd1);

      // Spurious starts during RUN and DONE are ignored
      a = 8'h12;
      b = 8'h34;
      start = 1'b1;
      tick();
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         start = (i % 2 == 0);
         a = 8'($urandom);
         b = 8'($urandom);
         tick();
         if (done) dones++;
      end
      check_value("ign_prod", {16'd0, product}, 32'h03A8);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dones++;
      end
      check_value("ign_dones", 32'(dones), 32'd1);
      check_value("ign_idle", {31'd0, busy}, 32'd0);
      prev_prod = 16'h03A8;

      // Reset during the 4th iteration
      a = 8'h21;
      b = 8'h43;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_value("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_value("mid_rst_done", {31'd0, done}, 32'd0);
      check_value("mid_rst_prod", {16'd0, product}, 32'd0);
      check_value("mid_rst_add", {16'd0, add_a, add_b}, 32'd0);
      tick();
      rst = 1'b0;
      prev_prod = 16'h0000;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dones++;
      end
      check_value("mid_rst_nodone", 32'(dones), 32'd0);
      mult_op(8'h03, 8'h05, "after_rst");

      // Back-to-back with start held high
      a = 8'h80;
      b = 8'h02;
      start = 1'b1;
      for (int i = 0; i < 33; i++) begin
         tick();
         if (done) begin
            times.push_back(i);
            check_value("b2b_prod", {16'd0, product}, 32'h0100);
         end
      end
      start = 1'b0;
      check_value("b2b_count", 32'(times.size()), 32'd3);
      if (times.size() == 3) begin
         check_value("b2b_first", 32'(times[0]), 32'd8);
         check_value("b2b_gap1", 32'(times[1] - times[0]), 32'd10);
         check_value("b2b_gap2", 32'(times[2] - times[1]), 32'd10);
      end
      for (int i = 0; i < 12; i++) tick();
      prev_prod = 16'h0100;

      mult_op(8'h00, 8'h77, "zero_a");
      mult_op(8'h5A, 8'h00, "zero_b");

      for (int i = 0; i < 20; i++) begin
         mult_op(8'($urandom), 8'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
